axi_read_resp_mem: RTL

// - AXI4 read-channel responder (slave) backed by an internal register-array memory of DATA_W-bit words.
// - Accepts one AR burst at a time and returns arlen+1 R beats with rid echoed, rresp, and rlast on the final beat.
// - Sits opposite the testbench read initiator and serves header/payload data preloaded through a side write port.
// - Used in simulation and as a synthesizable memory-model endpoint in subsystem tops.

---
 rtl/axi_read_resp_mem_pkg.sv | 18 +
 rtl/axi_burst_next_addr.sv | 34 +++
 rtl/axi_read_resp_mem.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axi_read_resp_mem_pkg.sv
// Shared AXI encodings and the read-responder FSM state type.
package axi_read_resp_mem_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational AXI burst address stepper: next beat address and WRAP legality.
module axi_burst_next_addr
    import axi_read_resp_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_legal
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic              len_ok;

    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
        incr_addr = addr + step;
        len_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        // WRAP start must sit on a beat boundary; the wrap window is (len+1) beats.
        wrap_legal = len_ok && ((addr & (step - ADDR_W'(1))) == '0);
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:         next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_resp_mem.sv
// AXI4 read responder over a preloadable register-array memory; one burst in flight.
module axi_read_resp_mem
    import axi_read_resp_mem_pkg::*;
#(
    parameter int ID_W     = 7,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int DEPTH    = 16,
    parameter int BEAT_GAP = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_mem_we,
    input  logic [$clog2(DEPTH)-1:0] i_mem_addr,
    input  logic [DATA_W-1:0]        i_mem_wdata,
    input  logic [ID_W-1:0]          arid,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [ID_W-1:0]          rid,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int ADDR_LSB = $clog2(DATA_W / 8);
    localparam logic [7:0] GAP_INIT = 8'(BEAT_GAP > 0 ? BEAT_GAP - 1 : 0);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Once rvalid is raised, rid/rdata/rresp/rlast stay frozen until that edge.

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q, cnt_q, gap_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q;

    logic              in_idle, accept, ar_hs, ld, gap_start;
    logic [ADDR_W-1:0] na_addr, nxt_addr, ld_addr;
    logic [2:0]        na_size;
    logic [7:0]        na_len, ld_cnt;
    logic [1:0]        na_burst;
    logic              wrap_legal, ar_err, ld_err;
    logic [IDX_W-1:0]  ld_idx;

    assign in_idle   = (state_q == ST_IDLE);
    assign accept    = rvalid && rready;
    assign dbg_state = state_q;

    // The stepper sees the incoming AR while idle (for legality) and the latched burst otherwise.
    assign na_addr  = in_idle ? araddr  : addr_q;
    assign na_size  = in_idle ? arsize  : size_q;
    assign na_len   = in_idle ? arlen   : len_q;
    assign na_burst = in_idle ? arburst : burst_q;

    axi_burst_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
        .addr       (na_addr),
        .size       (na_size),
        .len        (na_len),
        .burst      (na_burst),
        .next_addr  (nxt_addr),
        .wrap_legal (wrap_legal)
    );

    assign ar_err = (arburst == AXI_BURST_RSVD) || (arsize > 3'(ADDR_LSB)) ||
                    ((arburst == AXI_BURST_WRAP) && !wrap_legal);
    assign ld_err = (in_idle ? ar_err : err_q) ||
                    ((ld_addr >> ADDR_LSB) >= ADDR_W'(DEPTH));
    assign ld_idx = ld_addr[ADDR_LSB +: IDX_W];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        ld_addr   = addr_q;
        ld_cnt    = cnt_q;
        ar_hs     = 1'b0;
        gap_start = 1'b0;
        case (state_q)
            ST_IDLE: if (arvalid && arready) begin
                ar_hs   = 1'b1;
                ld      = 1'b1;
                ld_addr = araddr;
                ld_cnt  = 8'd0;
                state_d = ST_DATA;
            end
            ST_DATA: if (accept) begin
                if (rlast) begin
                    state_d = ST_IDLE;
                end else if (BEAT_GAP == 0) begin
                    ld      = 1'b1;
                    ld_addr = nxt_addr;
                    ld_cnt  = cnt_q + 8'd1;
                end else begin
                    gap_start = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: if (gap_q == 8'd0) begin
                ld      = 1'b1;
                state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= AXI_RESP_OKAY;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            arready <= (state_d == ST_IDLE);
            if (ar_hs) begin
                id_q    <= arid;
                len_q   <= arlen;
                size_q  <= arsize;
                burst_q <= arburst;
                err_q   <= ar_err;
            end
            if (ld) begin
                addr_q <= ld_addr;
                cnt_q  <= ld_cnt;
                rvalid <= 1'b1;
                rid    <= in_idle ? arid : id_q;
                rlast  <= (ld_cnt == (in_idle ? arlen : len_q));
                rresp  <= ld_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                rdata  <= ld_err ? '0 : mem[ld_idx];
            end else if (accept) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
                if (gap_start) begin
                    addr_q <= nxt_addr;
                    cnt_q  <= cnt_q + 8'd1;
                    gap_q  <= GAP_INIT;
                end
            end else if (state_q == ST_GAP) begin
                gap_q <= gap_q - 8'd1;
            end
        end
    end

    // Preload port; a same-edge R load reads the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_mem_we) mem[i_mem_addr] <= i_mem_wdata;
    end

endmodule
